// File: rtl/text_buffer_ctrl.sv
// Character-cell text controller: accepts glyph codes into a COLS x ROWS cell
// buffer, tracks a cursor, and resolves VGA pixels to glyph codes plus a
// blinking cursor flag with one cycle of latency.
module text_buffer_ctrl #(
  parameter int COLS         = 16,
  parameter int ROWS         = 16,
  parameter int CELL_PX      = 16,
  parameter int X_ORIGIN     = 80,
  parameter int Y_ORIGIN     = 80,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_valid,
  input  logic [4:0] ch_code,
  output logic       ch_ready,
  input  logic       frame_tick,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [4:0] glyph_code,
  output logic       in_text,
  output logic       cursor_on,
  output logic [3:0] x_select,
  output logic [3:0] y_select,
  output logic       busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int IDX_W = CW + RW;
  localparam int CELLS = COLS * ROWS;
  localparam int SH    = $clog2(CELL_PX);
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [CW-1:0]      cur_x_q, cur_x_d;
  logic [RW-1:0]      cur_y_q, cur_y_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [4:0]         glyph_code_q, glyph_code_d;
  logic               in_text_q, in_text_d;
  logic               cursor_on_q, cursor_on_d;

  logic [4:0]         mem [CELLS];
  logic               we;
  logic [IDX_W-1:0]   waddr;
  logic [4:0]         wdata;
  logic               accept;

  logic [CW-1:0]      adv_x, bs_x, rd_col;
  logic [RW-1:0]      adv_y, nl_y, bs_y, rd_row;

  assign ch_ready   = (state_q == IDLE);
  assign busy       = (state_q == CLEAR);
  assign x_select   = 4'(cur_x_q);
  assign y_select   = 4'(cur_y_q);
  assign glyph_code = glyph_code_q;
  assign in_text    = in_text_q;
  assign cursor_on  = cursor_on_q;

  // Candidate cursor positions for advance, newline and backspace.
  always_comb begin
    nl_y  = (cur_y_q == RW'(ROWS - 1)) ? '0 : cur_y_q + RW'(1);
    adv_x = (cur_x_q == CW'(COLS - 1)) ? '0 : cur_x_q + CW'(1);
    adv_y = (cur_x_q == CW'(COLS - 1)) ? nl_y : cur_y_q;
    bs_x  = cur_x_q;
    bs_y  = cur_y_q;
    if (cur_x_q != '0) begin
      bs_x = cur_x_q - CW'(1);
    end else if (cur_y_q != '0) begin
      bs_x = CW'(COLS - 1);
      bs_y = cur_y_q - RW'(1);
    end
  end

  // Controller next state: clear sweep, or code handling in IDLE.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    we        = 1'b0;
    waddr     = {cur_y_q, cur_x_q};
    wdata     = 5'd0;
    accept    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_idx_q;
        if (clr_idx_q == IDX_W'(CELLS - 1)) begin
          state_d = IDLE;
          cur_x_d = '0;
          cur_y_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      IDLE: begin
        if (ch_valid) begin
          accept = 1'b1;
          if (ch_code <= 5'd28) begin
            we      = 1'b1;
            wdata   = ch_code;
            cur_x_d = adv_x;
            cur_y_d = adv_y;
          end else if (ch_code == 5'd29) begin
            we      = 1'b1;
            waddr   = {bs_y, bs_x};
            cur_x_d = bs_x;
            cur_y_d = bs_y;
          end else if (ch_code == 5'd30) begin
            cur_x_d = '0;
            cur_y_d = nl_y;
          end else begin
            state_d   = CLEAR;
            clr_idx_d = '0;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Blink phase: an accepted code restarts the visible half-period.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (accept) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Pixel lookup; compares are done at 32 bits so pixels left of the origin never alias.
  always_comb begin
    in_text_d = ({22'd0, x} >= 32'(X_ORIGIN)) && ({22'd0, x} < 32'(X_ORIGIN + COLS * CELL_PX)) &&
                ({22'd0, y} >= 32'(Y_ORIGIN)) && ({22'd0, y} < 32'(Y_ORIGIN + ROWS * CELL_PX));
    rd_col       = CW'((x - 10'(X_ORIGIN)) >> SH);
    rd_row       = RW'((y - 10'(Y_ORIGIN)) >> SH);
    glyph_code_d = in_text_d ? mem[{rd_row, rd_col}] : 5'd0;
    cursor_on_d  = in_text_d && (rd_col == cur_x_q) && (rd_row == cur_y_q) && phase_q;
  end

  // Cell buffer write port; a same-cycle read sees the previous contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // State, cursor, blink and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      glyph_code_q <= 5'd0;
      in_text_q    <= 1'b0;
      cursor_on_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      glyph_code_q <= glyph_code_d;
      in_text_q    <= in_text_d;
      cursor_on_q  <= cursor_on_d;
    end
  end

endmodule
